cordic_vec_iter: RTL and testbench
==================================

Name: cordic_vec_iter

Overview:
- Iterative, multi-cycle CORDIC engine running in vectoring mode: cartesian (x, y) in, polar (magnitude, angle) out. It is the inverse of the rotation datapath, which turns polar into cartesian.
- Reuses one shift/add stage per cycle, driven by an FSM and an iteration counter.
- Valid/ready handshake on both input and output sides.
- Sits after the rotation-mode pipeline in the CORDIC subsystem, e.g. to recover phase/amplitude.

Parameters:
- NUM_ITER, 12: number of micro-rotations; valid range 4..16.
- IN_WIDTH, 16: signed width of i_x, i_y.
- DATA_OP_WIDTH, 18: internal and output signed width; must be at least IN_WIDTH+2.
- GAIN_COMP, 1: 1 multiplies the magnitude by 1/K (Q0.15 constant 19898); 0 outputs the raw K-scaled magnitude.

Ports:
- i_clk, in, 1: clock, rising edge.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_valid, in, 1: input operands valid.
- o_ready, out, 1: engine can accept input.
- i_x, in, IN_WIDTH: signed x operand.
- i_y, in, IN_WIDTH: signed y operand.
- o_valid, out, 1: result valid.
- i_ready, in, 1: downstream accepts result.
- o_mag, out, DATA_OP_WIDTH: signed magnitude, always >= 0.
- o_angle, out, DATA_OP_WIDTH: signed angle in radians, scale 2^15 per rad (FRAC_BITS=15).

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - State IDLE; counter 0.
  - o_valid=0, o_ready=1, o_mag=0, o_angle=0.
  - Internal x/y/z registers cleared.
  - Reset asserted in any state aborts the operation; no partial result is ever presented.
- FSM states: IDLE, ITER, SCALE, DONE.
  - o_ready = (state==IDLE).
  - o_valid = (state==DONE).
- IDLE:
  - On i_valid&&o_ready, sign-extend the operands to DATA_OP_WIDTH and pre-rotate:
    - x>=0: x,y,z = x, y, 0.
    - x<0, y>=0: -x, -y, +102944 (pi).
    - x<0, y<0: -x, -y, -102944.
  - Latch a zero flag (x==0 && y==0); counter=0; go to ITER.
  - -32768 negation must not overflow; the 18-bit internal width guarantees this.
- ITER:
  - Each cycle applies stage i = counter.
  - y>=0: x+= y>>>i, y-= x>>>i, z+= A[i].
  - Else: x-= y>>>i, y+= x>>>i, z-= A[i].
  - Both updates use pre-update x and y; shifts are arithmetic with truncation.
  - A[i] = round(atan(2^-i)*2^15): 25736, 15193, 8027, 4075, 2045, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1 (i = 0..15).
  - When counter==NUM_ITER-1, go to SCALE; otherwise counter+1.
- SCALE, one cycle:
  - o_mag = GAIN_COMP ? (x*19898)>>>15 (35-bit product, truncated) : x.
  - o_angle = z.
  - If the zero flag is set, force o_mag=0 and o_angle=0.
  - Go to DONE.
- DONE:
  - o_mag and o_angle are held stable.
  - When i_ready=1, go to IDLE on the next edge; o_ready=1 the following cycle.
  - While i_ready=0, hold indefinitely.
  - i_valid is ignored outside IDLE.
- Latency: o_valid rises NUM_ITER+1 cycles after the accepting edge.
  - Throughput: one result per NUM_ITER+3 cycles when i_ready is held at 1.
- Angle boundaries:
  - (x<0, y=0) yields approximately +pi.
  - The result may exceed +/-pi by convergence error of at most A[NUM_ITER-1]; no wrapping or saturation is applied.
- Range: |raw x| <= 1.6468*32768*sqrt(2) < 2^17, so no overflow at DATA_OP_WIDTH=18.

Test Plan:
- Reset then (16384, 0) -> o_valid at cycle 13 after accept; o_angle=0+/-24; o_mag=16384+/-16.
- (0, 16384) -> o_angle=51472+/-24; o_mag=16384+/-16.
- (-16384, 0) -> o_angle=102944+/-24 (positive pi); (-16384, -16384) -> o_angle=-77208+/-24, o_mag=23170+/-16.
- (0, 0) -> o_mag=0, o_angle=0 exactly. Repeat (16384, 0) with GAIN_COMP=0 -> o_mag=26982+/-24.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid, while pulsing i_valid with new operands -> outputs stable, o_ready=0, nothing accepted. Then i_ready=1 -> o_valid=0 and o_ready=1 the next cycle.
- Assert i_rst_n=0 mid-ITER (counter=5) -> o_valid=0 and o_ready=1 immediately. After release, (16384, 16384) -> o_angle=25736+/-24, o_mag=23170+/-16.

Source files
------------

// File: rtl/cordic_vec_iter_if.sv
// Handshake bundle for the vectoring CORDIC engine: operand request in, polar result out.
`timescale 1ns/1ps
interface cordic_vec_iter_if #(
    parameter int IN_WIDTH      = 16,
    parameter int DATA_OP_WIDTH = 18
);
    // Both directions: a transfer happens on a rising edge where valid and ready
    // are both high; the producer holds valid and its data until that edge.
    logic                            i_valid;
    logic                            o_ready;
    logic signed [IN_WIDTH-1:0]      i_x;
    logic signed [IN_WIDTH-1:0]      i_y;
    logic                            o_valid;
    logic                            i_ready;
    logic signed [DATA_OP_WIDTH-1:0] o_mag;
    logic signed [DATA_OP_WIDTH-1:0] o_angle;

    modport slave (
        input  i_valid, i_x, i_y, i_ready,
        output o_ready, o_valid, o_mag, o_angle
    );

    modport master (
        output i_valid, i_x, i_y, i_ready,
        input  o_ready, o_valid, o_mag, o_angle
    );
endinterface

// File: rtl/cordic_vec_iter.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (magnitude, angle), one micro-rotation per cycle.
`timescale 1ns/1ps
module cordic_vec_iter #(
    parameter int NUM_ITER      = 12,
    parameter int IN_WIDTH      = 16,
    parameter int DATA_OP_WIDTH = 18,
    parameter int GAIN_COMP     = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    cordic_vec_iter_if.slave    io_if,
    output logic [1:0]          o_dbg_state,
    output logic [3:0]          o_dbg_cnt
);
    localparam int DW = DATA_OP_WIDTH;
    localparam int PW = DW + 17;
    localparam logic signed [DW-1:0] PI_Q15    = DW'(102944);
    localparam logic signed [PW-1:0] INV_K_Q15 = PW'(19898);
    localparam logic [3:0]           LAST_ITER = 4'(NUM_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic signed [DW-1:0]  r_x;
    logic signed [DW-1:0]  r_y;
    logic signed [DW-1:0]  r_z;
    logic                  r_zero;
    logic                  r_valid;
    logic                  r_ready;
    logic signed [DW-1:0]  r_mag;
    logic signed [DW-1:0]  r_angle;

    logic signed [DW-1:0]  w_x_ext;
    logic signed [DW-1:0]  w_y_ext;
    logic signed [DW-1:0]  w_x_sh;
    logic signed [DW-1:0]  w_y_sh;
    logic signed [DW-1:0]  w_atan;
    logic signed [PW-1:0]  w_prod;
    logic signed [DW-1:0]  w_mag;

    // round(atan(2^-i) * 2^15)
    function automatic logic signed [DW-1:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = DW'(25736);
            4'd1:    atan_lut = DW'(15193);
            4'd2:    atan_lut = DW'(8027);
            4'd3:    atan_lut = DW'(4075);
            4'd4:    atan_lut = DW'(2045);
            4'd5:    atan_lut = DW'(1024);
            4'd6:    atan_lut = DW'(512);
            4'd7:    atan_lut = DW'(256);
            4'd8:    atan_lut = DW'(128);
            4'd9:    atan_lut = DW'(64);
            4'd10:   atan_lut = DW'(32);
            4'd11:   atan_lut = DW'(16);
            4'd12:   atan_lut = DW'(8);
            4'd13:   atan_lut = DW'(4);
            4'd14:   atan_lut = DW'(2);
            default: atan_lut = DW'(1);
        endcase
    endfunction

    assign w_x_ext = {{(DW-IN_WIDTH){io_if.i_x[IN_WIDTH-1]}}, io_if.i_x};
    assign w_y_ext = {{(DW-IN_WIDTH){io_if.i_y[IN_WIDTH-1]}}, io_if.i_y};
    assign w_x_sh  = r_x >>> r_cnt;
    assign w_y_sh  = r_y >>> r_cnt;
    assign w_atan  = atan_lut(r_cnt);

    // x is non-negative after pre-rotation, so the truncating shift rounds toward zero.
    assign w_prod  = PW'(r_x) * INV_K_Q15;
    assign w_mag   = (GAIN_COMP != 0) ? DW'(w_prod >>> 15) : r_x;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_mag   <= '0;
            r_angle <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_if.i_valid) begin
                        // Fold the left half-plane onto the right so the iterations converge.
                        if (!w_x_ext[DW-1]) begin
                            r_x <= w_x_ext;
                            r_y <= w_y_ext;
                            r_z <= '0;
                        end else begin
                            r_x <= -w_x_ext;
                            r_y <= -w_y_ext;
                            r_z <= w_y_ext[DW-1] ? -PI_Q15 : PI_Q15;
                        end
                        r_zero  <= (io_if.i_x == '0) && (io_if.i_y == '0);
                        r_cnt   <= 4'd0;
                        r_ready <= 1'b0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (!r_y[DW-1]) begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - w_atan;
                    end
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_SCALE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SCALE: begin
                    r_mag   <= r_zero ? '0 : w_mag;
                    r_angle <= r_zero ? '0 : r_z;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (io_if.i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_if.o_ready   = r_ready;
    assign io_if.o_valid   = r_valid;
    assign io_if.o_mag     = r_mag;
    assign io_if.o_angle   = r_angle;
    assign o_dbg_state     = r_state;
    assign o_dbg_cnt       = r_cnt;

endmodule

// File: tb/tb_cordic_vec_iter.sv
// Directed bench for cordic_vec_iter: scoreboard queues checked by output monitors.
`timescale 1ns/1ps
module tb_cordic_vec_iter;
    localparam int IW = 16;
    localparam int DW = 18;
    localparam int NI = 12;
    localparam int EW = 2*DW + 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_vec_iter_if #(.IN_WIDTH(IW), .DATA_OP_WIDTH(DW)) bus();
    cordic_vec_iter_if #(.IN_WIDTH(IW), .DATA_OP_WIDTH(DW)) bus_ng();

    logic [1:0] dbg_state;
    logic [3:0] dbg_cnt;
    logic [1:0] dbg_state_ng;
    logic [3:0] dbg_cnt_ng;

    cordic_vec_iter #(.NUM_ITER(NI), .IN_WIDTH(IW), .DATA_OP_WIDTH(DW), .GAIN_COMP(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .io_if(bus.slave),
        .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
    );

    cordic_vec_iter #(.NUM_ITER(NI), .IN_WIDTH(IW), .DATA_OP_WIDTH(DW), .GAIN_COMP(0)) dut_ng (
        .i_clk(clk), .i_rst_n(rst_n), .io_if(bus_ng.slave),
        .o_dbg_state(dbg_state_ng), .o_dbg_cnt(dbg_cnt_ng)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_qn[$];
    logic [EW-1:0] e_mon;
    logic [EW-1:0] e_mon_ng;

    function automatic logic [EW-1:0] mk_exp(input int mag, input int ang, input int tm, input int ta);
        return {DW'(mag), DW'(ang), 8'(tm), 8'(ta)};
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (absdiff(act, exp) > tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        check_near(name, act, exp, 0);
    endtask

    task automatic sb_compare(input string tag, input logic [EW-1:0] e, input int mag, input int ang);
        check_near({tag, "_mag"}, mag, int'($signed(e[EW-1 -: DW])), int'(e[15:8]));
        check_near({tag, "_angle"}, ang, int'($signed(e[EW-DW-1 -: DW])), int'(e[7:0]));
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: result mag=%0d angle=%0d, none expected", bus.o_mag, bus.o_angle);
            end else begin
                e_mon = exp_q.pop_front();
                sb_compare("sb", e_mon, int'(bus.o_mag), int'(bus.o_angle));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_ng.o_valid && bus_ng.i_ready) begin
            if (exp_qn.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_ng_unexpected: result mag=%0d angle=%0d, none expected", bus_ng.o_mag, bus_ng.o_angle);
            end else begin
                e_mon_ng = exp_qn.pop_front();
                sb_compare("sb_ng", e_mon_ng, int'(bus_ng.o_mag), int'(bus_ng.o_angle));
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic send(input bit sel, input int x, input int y, input bit push,
                        input int mag, input int ang, input int tm, input int ta);
        bit rdy;
        bit done;
        done = 1'b0;
        if (push && !sel) exp_q.push_back(mk_exp(mag, ang, tm, ta));
        if (push && sel)  exp_qn.push_back(mk_exp(mag, ang, tm, ta));
        if (sel) begin
            bus_ng.i_valid = 1'b1; bus_ng.i_x = IW'(x); bus_ng.i_y = IW'(y);
        end else begin
            bus.i_valid = 1'b1; bus.i_x = IW'(x); bus.i_y = IW'(y);
        end
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            rdy = sel ? bus_ng.o_ready : bus.o_ready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        bus.i_valid    = 1'b0;
        bus_ng.i_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: o_ready=0, want 1 within 100 cycles");
        end
    endtask

    task automatic wait_idle(input bit sel);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            #1;
            done = sel ? bus_ng.o_ready : bus.o_ready;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: o_ready=0, want 1 within 100 cycles");
        end
    endtask

    task automatic wait_valid(output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            #1;
            n++;
            done = bus.o_valid;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: o_valid=0, want 1 within 100 cycles");
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bit hit;
        bus.i_valid = 1'b0; bus.i_x = '0; bus.i_y = '0; bus.i_ready = 1'b1;
        bus_ng.i_valid = 1'b0; bus_ng.i_x = '0; bus_ng.i_y = '0; bus_ng.i_ready = 1'b1;

        #12;
        check_eq("rst_o_valid", int'(bus.o_valid), 0);
        check_eq("rst_o_ready", int'(bus.o_ready), 1);
        check_eq("rst_o_mag",   int'(bus.o_mag), 0);
        check_eq("rst_o_angle", int'(bus.o_angle), 0);
        check_eq("rst_state",   int'(dbg_state), 0);
        check_eq("rst_cnt",     int'(dbg_cnt), 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(1'b0, 16384, 0, 1'b1, 16384, 0, 16, 24);
        wait_valid(n);
        check_eq("latency", n, NI + 1);
        wait_idle(1'b0);

        send(1'b0, 0, 16384, 1'b1, 16384, 51472, 16, 24);
        wait_idle(1'b0);
        send(1'b0, -16384, 0, 1'b1, 16384, 102944, 16, 24);
        wait_idle(1'b0);
        send(1'b0, -16384, -16384, 1'b1, 23170, -77208, 16, 24);
        wait_idle(1'b0);
        send(1'b0, 0, 0, 1'b1, 0, 0, 0, 0);
        wait_idle(1'b0);

        send(1'b1, 16384, 0, 1'b1, 26982, 0, 24, 24);
        wait_idle(1'b1);

        // Backpressure: result must hold while new requests are ignored.
        bus.i_ready = 1'b0;
        send(1'b0, -16384, 16384, 1'b1, 23170, 77208, 16, 24);
        wait_valid(n);
        check_eq("latency_bp", n, NI + 1);
        for (int c = 0; c < 5; c++) begin
            bus.i_valid = (c % 2 == 0);
            bus.i_x = IW'(1000 * (c + 1));
            bus.i_y = IW'(-500 * (c + 1));
            @(negedge clk);
            check_eq("bp_o_valid", int'(bus.o_valid), 1);
            check_eq("bp_o_ready", int'(bus.o_ready), 0);
            check_eq("bp_state", int'(dbg_state), 3);
            check_near("bp_o_mag", int'(bus.o_mag), 23170, 16);
            check_near("bp_o_angle", int'(bus.o_angle), 77208, 24);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_o_valid", int'(bus.o_valid), 0);
        check_eq("rel_o_ready", int'(bus.o_ready), 1);
        @(posedge clk); #1;
        check_eq("rel_state_idle", int'(dbg_state), 0);

        // Abort mid-iteration; the aborted operation never produces a result.
        send(1'b0, 16384, 0, 1'b0, 0, 0, 0, 0);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            hit = (dbg_state == 2'd1) && (dbg_cnt == 4'd5);
            if (!hit) begin
                @(posedge clk); #1;
            end
        end
        check_eq("reach_cnt5", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_o_valid", int'(bus.o_valid), 0);
        check_eq("abort_o_ready", int'(bus.o_ready), 1);
        check_eq("abort_state",   int'(dbg_state), 0);
        check_eq("abort_o_mag",   int'(bus.o_mag), 0);
        check_eq("abort_o_angle", int'(bus.o_angle), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(1'b0, 16384, 16384, 1'b1, 23170, 25736, 16, 24);
        wait_idle(1'b0);
        @(posedge clk); #1;

        check_eq("sb_drained", exp_q.size() + exp_qn.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
